// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and round defaults for the duck-hunt game
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    RELOADING = 2'd2,
    OVER      = 2'd3
  } game_state_t;

  localparam int MAG_SIZE_DEF   = 4;
  localparam int ROUND_SECS_DEF = 30;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - 2-FF synchronizer plus edge register with rising/falling edge flags
// BYPASS skips the first flop for inputs that are already vga_clk-synchronous.
module btn_edge #(
  parameter bit BYPASS = 1'b0
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic btn,
  output logic rise,
  output logic fall
);

  logic meta;
  logic level;
  logic level_prev;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      meta       <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
    end else begin
      meta       <= btn;
      level      <= BYPASS ? btn : meta;
      level_prev <= level;
    end
  end

  assign rise = level & ~level_prev;
  assign fall = ~level & level_prev;

endmodule

// File: rtl/game_round_controller.sv
// rtl/game_round_controller.sv - round FSM, magazine, countdown and score for one duck-hunt round
// Fire requests become single-cycle shot grants; run freezes the playfield outside a round.
module game_round_controller
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 25_000_000,
  parameter int ROUND_SECS    = ROUND_SECS_DEF,
  parameter int MAG_SIZE      = MAG_SIZE_DEF,
  parameter int RELOAD_CYCLES = 12_500_000,
  parameter int SCORE_W       = 8
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               start,
  input  logic               fire,
  input  logic               reload,
  input  logic               hit,
  output logic               shot_grant,
  output logic               run,
  output logic [2:0]         ammo,
  output logic [4:0]         secs_left,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state,
  output logic               round_over
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int RLD_W = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;

  localparam logic [2:0]         MAG       = 3'(MAG_SIZE);
  localparam logic [4:0]         SECS      = 5'(ROUND_SECS);
  localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [RLD_W-1:0]   RLD_LOAD  = RLD_W'(RELOAD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic start_rise, fire_rise, reload_rise, hit_fall;
  logic start_fall, fire_fall, reload_fall, hit_rise;
  logic unused_edges;

  btn_edge #(.BYPASS(1'b0)) u_start  (.vga_clk(vga_clk), .reset(reset), .btn(start),  .rise(start_rise),  .fall(start_fall));
  btn_edge #(.BYPASS(1'b0)) u_fire   (.vga_clk(vga_clk), .reset(reset), .btn(fire),   .rise(fire_rise),   .fall(fire_fall));
  btn_edge #(.BYPASS(1'b0)) u_reload (.vga_clk(vga_clk), .reset(reset), .btn(reload), .rise(reload_rise), .fall(reload_fall));
  btn_edge #(.BYPASS(1'b1)) u_hit    (.vga_clk(vga_clk), .reset(reset), .btn(hit),    .rise(hit_rise),    .fall(hit_fall));

  assign unused_edges = &{1'b0, start_fall, fire_fall, reload_fall, hit_rise};

  game_state_t        state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [RLD_W-1:0]   rcnt_q, rcnt_d;
  logic [2:0]         ammo_d;
  logic [4:0]         secs_d;
  logic [SCORE_W-1:0] score_d;
  logic               grant_d;
  logic               active, tick, expire;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      rcnt_q     <= '0;
      ammo       <= MAG;
      secs_left  <= SECS;
      score      <= '0;
      shot_grant <= 1'b0;
      run        <= 1'b0;
      round_over <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      rcnt_q     <= rcnt_d;
      ammo       <= ammo_d;
      secs_left  <= secs_d;
      score      <= score_d;
      shot_grant <= grant_d;
      run        <= (state_d == PLAY) || (state_d == RELOADING);
      round_over <= (state_d == OVER);
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    rcnt_d  = rcnt_q;
    ammo_d  = ammo;
    secs_d  = secs_left;
    score_d = score;
    grant_d = 1'b0;

    active = (state_q == PLAY) || (state_q == RELOADING);
    tick   = active && (pre_q == PRE_MAX);
    expire = tick && (secs_left == 5'd1);

    if (active) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) secs_d = secs_left - 5'd1;
      if (hit_fall && (score != SCORE_MAX)) score_d = score + 1'b1;
    end

    // Expiry outranks everything else, so a reload in flight is abandoned with ammo as-is.
    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          state_d = PLAY;
          ammo_d  = MAG;
          score_d = '0;
          secs_d  = SECS;
          pre_d   = '0;
        end
      end
      PLAY: begin
        if (expire) begin
          state_d = OVER;
        end else if (reload_rise && (ammo < MAG)) begin
          state_d = RELOADING;
          rcnt_d  = RLD_LOAD;
        end else if (fire_rise && (ammo != 3'd0)) begin
          grant_d = 1'b1;
          ammo_d  = ammo - 3'd1;
        end
      end
      RELOADING: begin
        if (expire) begin
          state_d = OVER;
        end else if (rcnt_q == '0) begin
          state_d = PLAY;
          ammo_d  = MAG;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_round_controller.sv
// tb/tb_game_round_controller.sv - scoreboard bench for game_round_controller
// Stimulus queues timestamped snapshots; the monitor checks each visible output event against them.
module tb_game_round_controller;

  logic       vga_clk;
  logic       reset;
  logic       start, fire, reload, hit;
  logic       shot_grant, run, round_over;
  logic [2:0] ammo;
  logic [4:0] secs_left;
  logic [7:0] score;
  logic [1:0] state;

  game_round_controller #(
    .TICKS_PER_SEC(10),
    .ROUND_SECS(3),
    .MAG_SIZE(4),
    .RELOAD_CYCLES(5),
    .SCORE_W(8)
  ) dut (
    .vga_clk(vga_clk),
    .reset(reset),
    .start(start),
    .fire(fire),
    .reload(reload),
    .hit(hit),
    .shot_grant(shot_grant),
    .run(run),
    .ammo(ammo),
    .secs_left(secs_left),
    .score(score),
    .state(state),
    .round_over(round_over)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int st;
    int ammo;
    int secs;
    int score;
    int grant;
  } exp_t;

  exp_t exp_q[$];
  bit   done = 1'b0;

  task automatic push(input int c, input int st, input int am, input int se, input int sc, input int gr);
    exp_t e;
    e.cyc = c; e.st = st; e.ammo = am; e.secs = se; e.score = sc; e.grant = gr;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge vga_clk);
  endtask

  // Monitor: one comparison per visible output event, plus end-of-run checks.
  int       tests = 0;
  int       fails = 0;
  bit       primed = 1'b0;
  bit       ev;
  logic [1:0] p_state;
  logic [2:0] p_ammo;
  logic [7:0] p_score;
  logic       p_run, p_over;
  exp_t       m;
  int         want_run, want_over;

  always @(negedge vga_clk) begin
    if (cyc >= 3) begin
      ev = !primed || shot_grant || (state != p_state) || (ammo != p_ammo) ||
           (score != p_score) || (run != p_run) || (round_over != p_over);
      primed = 1'b1;
      if (ev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event cyc=%0d got st=%0d ammo=%0d secs=%0d score=%0d grant=%0d want no event",
                   cyc, state, ammo, secs_left, score, shot_grant);
        end else begin
          m = exp_q.pop_front();
          want_run  = (m.st == 1 || m.st == 2) ? 1 : 0;
          want_over = (m.st == 3) ? 1 : 0;
          if (cyc != m.cyc || state != m.st || ammo != m.ammo || secs_left != m.secs ||
              score != m.score || shot_grant != m.grant || run != want_run || round_over != want_over) begin
            fails++;
            $display("FAIL event got cyc=%0d st=%0d ammo=%0d secs=%0d score=%0d grant=%0d run=%0d over=%0d want cyc=%0d st=%0d ammo=%0d secs=%0d score=%0d grant=%0d run=%0d over=%0d",
                     cyc, state, ammo, secs_left, score, shot_grant, run, round_over,
                     m.cyc, m.st, m.ammo, m.secs, m.score, m.grant, want_run, want_over);
          end
        end
      end
      p_state = state; p_ammo = ammo; p_score = score; p_run = run; p_over = round_over;
    end
    if (done) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL missing_events got %0d pending, want 0 (next cyc=%0d)", exp_q.size(), exp_q[0].cyc);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end else if (cyc > 1000) begin
      tests++;
      fails++;
      $display("FAIL timeout got cyc=%0d want stimulus done", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  int n, p, p2, p3;

  initial begin
    reset = 1'b1; start = 1'b0; fire = 1'b0; reload = 1'b0; hit = 1'b0;
    // reset state, sampled on the first monitored cycle
    push(3, 0, 4, 3, 0, 0);
    wait_until(3);
    reset = 1'b0;

    // Round 1: five shots, reload from empty, three hits, expiry, hit in OVER
    wait_until(5);
    n = cyc; p = n + 3;
    push(p,      1, 4, 3, 0, 0);
    push(p + 4,  1, 3, 3, 0, 1);
    push(p + 6,  1, 2, 3, 0, 1);
    push(p + 8,  1, 1, 3, 0, 1);
    push(p + 10, 1, 0, 2, 0, 1);
    push(p + 16, 2, 0, 2, 0, 0);
    push(p + 21, 1, 4, 1, 0, 0);
    push(p + 25, 1, 4, 1, 1, 0);
    push(p + 27, 1, 4, 1, 2, 0);
    push(p + 29, 1, 4, 1, 3, 0);
    push(p + 30, 3, 4, 0, 3, 0);
    start = 1'b1; wait_until(n + 1); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_until(p + 1 + 2 * k); fire = 1'b1;
      wait_until(p + 2 + 2 * k); fire = 1'b0;
    end
    wait_until(p + 13); reload = 1'b1;
    wait_until(p + 14); reload = 1'b0;
    wait_until(p + 17); fire = 1'b1;
    wait_until(p + 18); fire = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_until(p + 22 + 2 * k); hit = 1'b1;
      wait_until(p + 23 + 2 * k); hit = 1'b0;
    end
    wait_until(p + 31); hit = 1'b1;
    wait_until(p + 32); hit = 1'b0;

    // Round 2 from OVER: hit + shots, fire and reload together, reset mid-reload
    wait_until(p + 36);
    n = cyc; p2 = n + 3;
    push(p2,      1, 4, 3, 0, 0);
    push(p2 + 4,  1, 3, 3, 1, 1);
    push(p2 + 6,  1, 2, 3, 1, 1);
    push(p2 + 10, 2, 2, 2, 1, 0);
    push(p2 + 12, 0, 4, 3, 0, 0);
    start = 1'b1; wait_until(n + 1); start = 1'b0;
    wait_until(p2 + 1); fire = 1'b1; hit = 1'b1;
    wait_until(p2 + 2); fire = 1'b0; hit = 1'b0;
    wait_until(p2 + 3); fire = 1'b1;
    wait_until(p2 + 4); fire = 1'b0;
    wait_until(p2 + 7); fire = 1'b1; reload = 1'b1;
    wait_until(p2 + 8); fire = 1'b0; reload = 1'b0;
    wait_until(p2 + 11); reset = 1'b1;
    wait_until(p2 + 12); reset = 1'b0;

    // Round 3 from IDLE: full-mag reload ignored, start in PLAY ignored, expiry with fire and hit
    wait_until(p2 + 15);
    n = cyc; p3 = n + 3;
    push(p3,      1, 4, 3, 0, 0);
    push(p3 + 6,  1, 3, 3, 0, 1);
    push(p3 + 30, 3, 3, 0, 1, 0);
    start = 1'b1; wait_until(n + 1); start = 1'b0;
    wait_until(p3 + 1); reload = 1'b1;
    wait_until(p3 + 2); reload = 1'b0;
    wait_until(p3 + 3); fire = 1'b1;
    wait_until(p3 + 4); fire = 1'b0;
    wait_until(p3 + 10); start = 1'b1;
    wait_until(p3 + 11); start = 1'b0;
    wait_until(p3 + 27); fire = 1'b1; hit = 1'b1;
    wait_until(p3 + 28); fire = 1'b0; hit = 1'b0;
    wait_until(p3 + 36);
    done = 1'b1;
  end

endmodule
